// File: rtl/raisin64_run_ctrl.sv
// raisin64 run controller: sequences the core reset, supervises the run and
// stops it on halt request, PC self-loop or cycle-budget timeout, while
// keeping cycle and retired-instruction counts for pass/fail and perf readout.
module raisin64_run_ctrl #(
  parameter int unsigned PC_W           = 64,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned STALL_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             retire,
  input  logic             halt_req,
  output logic             cpu_rst_n,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] STALL_LIM   = CNT_W'(STALL_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam bit               STALL_EN    = (STALL_CYCLES != 0);

  state_t           state;
  logic [CNT_W-1:0] rst_len;
  logic [CNT_W-1:0] stall_cnt;
  logic [PC_W-1:0]  prev_pc;
  logic             prev_valid;

  logic [CNT_W-1:0] cyc_inc_c;
  logic [CNT_W-1:0] ret_inc_c;
  logic [CNT_W-1:0] stall_nxt_c;
  logic             pc_same_c;
  logic             halt_hit_c;
  logic             timeout_hit_c;

  // Saturating counter updates and this cycle's exit conditions while in RUN.
  always_comb begin
    cyc_inc_c     = cycle_cnt;
    ret_inc_c     = retire_cnt;
    stall_nxt_c   = '0;
    pc_same_c     = 1'b0;
    halt_hit_c    = 1'b0;
    timeout_hit_c = 1'b0;

    if (cycle_cnt != CNT_MAX) cyc_inc_c = cycle_cnt + CNT_ONE;
    if (retire && (retire_cnt != CNT_MAX)) ret_inc_c = retire_cnt + CNT_ONE;

    // First RUN cycle has no valid previous PC, so it always counts as a change.
    pc_same_c = prev_valid && (pc == prev_pc);
    if (pc_same_c) begin
      if (stall_cnt >= STALL_LIM) stall_nxt_c = STALL_LIM;
      else                        stall_nxt_c = stall_cnt + CNT_ONE;
    end

    halt_hit_c    = halt_req || (STALL_EN && (stall_nxt_c == STALL_LIM));
    timeout_hit_c = TIMEOUT_EN && (cyc_inc_c == TIMEOUT_LIM);
  end

  // Run-control FSM with registered outputs; rst overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cpu_rst_n  <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      halted     <= 1'b0;
      timed_out  <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      rst_len    <= '0;
      stall_cnt  <= '0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RESET;
            rst_len    <= RESET_LOAD;
            cpu_rst_n  <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            timed_out  <= 1'b0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            prev_valid <= 1'b0;
          end
        end
        S_RESET: begin
          // Release lands RESET_CYCLES+1 edges after the start edge.
          if (rst_len == '0) begin
            state     <= S_RUN;
            cpu_rst_n <= 1'b1;
            running   <= 1'b1;
          end else begin
            rst_len <= rst_len - CNT_ONE;
          end
        end
        S_RUN: begin
          cycle_cnt  <= cyc_inc_c;
          retire_cnt <= ret_inc_c;
          stall_cnt  <= stall_nxt_c;
          prev_pc    <= pc;
          prev_valid <= 1'b1;
          // Halt has priority over a coincident timeout.
          if (halt_hit_c || timeout_hit_c) begin
            state     <= S_DONE;
            cpu_rst_n <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b1;
            halted    <= halt_hit_c;
            timed_out <= !halt_hit_c;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/raisin64_run_ctrl.md
Name: raisin64_run_ctrl

Overview:
- Synthesisable run controller for the raisin64 core, used on the FPGA top and in simulation benches.
- Sequences the core's active-low reset for a programmable number of cycles, then lets the core run.
- Stops the run on an explicit halt, on a PC self-loop (branch-to-self idiom), or on a cycle-budget timeout.
- Reports cycle and retired-instruction counts for pass/fail checking and performance readout.

Parameters:
- PC_W, 64, width of the monitored program counter.
- CNT_W, 32, width of the cycle and retire counters.
- RESET_CYCLES, 2, cycles cpu_rst_n is held low after start; legal range is 1..2^CNT_W-1.
- TIMEOUT_CYCLES, 40, run-cycle budget; 0 disables the timeout.
- STALL_CYCLES, 4, consecutive cycles with an unchanged PC that count as a halt; 0 disables self-loop detection.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- pc  in  PC_W  core fetch PC, sampled every cycle in RUN.
- retire  in  1  core retired one instruction this cycle.
- halt_req  in  1  core executed its halt/trap-to-host instruction.
- cpu_rst_n  out  1  registered active-low reset to the core.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- halted  out  1  the run ended by halt_req or PC self-loop; valid while done=1.
- timed_out  out  1  the run ended by timeout; valid while done=1.
- cycle_cnt  out  CNT_W  RUN cycles elapsed in the current or last run.
- retire_cnt  out  CNT_W  instructions retired in the current or last run.

Behaviour:
- Reset (rst=1 at an edge): next state IDLE. cpu_rst_n=0, running=0, done=0, halted=0, timed_out=0, cycle_cnt=0, retire_cnt=0, stall counter=0. rst has priority over every other input in every state, including mid-RESET and mid-RUN.
- States: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE: cpu_rst_n=0. start=1 moves to RESET. The same edge clears the counters and the flags and loads the reset-length counter with RESET_CYCLES.
- RESET: cpu_rst_n=0. The reset-length counter decrements each cycle; on the edge where it reaches 0, go to RUN.
  - The first cycle with cpu_rst_n=1 is exactly RESET_CYCLES+1 edges after the edge that sampled start.
  - start is ignored in RESET.
- RUN: cpu_rst_n=1, running=1.
  - cycle_cnt increments every cycle and saturates at all-ones.
  - retire_cnt increments when retire=1 and also saturates.
  - Stall counter: compare pc with the previous cycle's pc. If equal, increment (saturating at STALL_CYCLES); if different, clear. The first RUN cycle compares against an invalid marker and counts as different.
  - Exit conditions, all evaluated in the same cycle:
    - halt = halt_req=1, or (STALL_CYCLES!=0 and the stall counter reaches STALL_CYCLES this cycle).
    - timeout = TIMEOUT_CYCLES!=0 and the post-increment cycle_cnt equals TIMEOUT_CYCLES.
  - On halt or timeout, go to DONE at the next edge and set halted or timed_out. The counters include that final cycle.
  - If halt and timeout occur in the same cycle, halt wins: halted=1, timed_out=0.
  - start is ignored in RUN.
- DONE: cpu_rst_n=0 (core frozen), running=0, done=1. Counters and flags hold. retire and halt_req are ignored. start=1 behaves as in IDLE: counters clear and the flags drop on that edge.
- Exactly one of halted and timed_out is 1 whenever done=1.

Test Plan:
- rst=1 for 2 cycles, then start pulsed one cycle, RESET_CYCLES=2 -> cpu_rst_n low through reset and for 2 cycles after the start edge; cpu_rst_n=1 and running=1 on the 3rd edge after start.
- In RUN, pc incrementing by 4 every cycle, retire=1 on alternate cycles, halt_req=1 on the 10th RUN cycle -> next edge done=1, halted=1, timed_out=0, cycle_cnt=10, retire_cnt=5, cpu_rst_n=0.
- pc held at 0x100 from the 6th RUN cycle onward, STALL_CYCLES=4, no halt_req -> done=1, halted=1, cycle_cnt=10.
- pc always changing, no halt_req, TIMEOUT_CYCLES=40 -> done=1, timed_out=1, cycle_cnt=40. Rerun with halt_req=1 on RUN cycle 40 -> halted=1, timed_out=0.
- start pulsed in RUN and in RESET -> no effect. start in DONE -> counters 0 on the next edge, new RESET sequence, flags cleared.
- rst=1 mid-RUN with cycle_cnt=7 -> next edge IDLE, all outputs at reset values, and start is not required to be held.
